// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle for apb_slave_mem; clock and reset stay plain ports.
interface apb_slave_mem_if;
  logic [31:0] p_addr;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        p_slverr;

  modport master (
    output p_addr, p_sel, p_enable, p_write, p_wdata, p_strb,
    input  p_rdata, p_ready, p_slverr
  );

  modport slave (
    input  p_addr, p_sel, p_enable, p_write, p_wdata, p_strb,
    output p_rdata, p_ready, p_slverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB word-addressed memory slave: byte strobes, fixed wait states, PSLVERR on bad accesses.
// Word 0 is a read-only ID register.
module apb_slave_mem #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              p_clk,
  input  logic              p_resetn,
  apb_slave_mem_if.slave    apb
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          wr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic          err;
  } req_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  req_t        req;
  logic        latch;
  logic        ready;
  logic        set_err;
  logic [31:0] mem [DEPTH];

  // Error classification is done at setup so the access phase only needs the latched flag.
  always_comb begin
    set_err = (apb.p_addr[1:0] != 2'b00)
            | ({2'b00, apb.p_addr[31:2]} >= 32'(DEPTH))
            | (apb.p_write & (apb.p_addr[31:2] == 30'd0));
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    latch   = 1'b0;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        // Enable without a preceding setup phase is ignored.
        if (apb.p_sel && !apb.p_enable) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.p_sel) begin
          state_d = IDLE;
        end else if (apb.p_enable) begin
          if (cnt != 4'd0) begin
            cnt_d = cnt - 4'd1;
          end else begin
            ready   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      req <= '0;
    end else if (latch) begin
      req.idx   <= apb.p_addr[AW+1:2];
      req.wr    <= apb.p_write;
      req.wdata <= apb.p_wdata;
      req.strb  <= apb.p_strb;
      req.err   <= set_err;
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      mem[0] <= ID_VALUE;
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (ready && req.wr && !req.err) begin
      for (int b = 0; b < 4; b++)
        if (req.strb[b]) mem[req.idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end

  assign apb.p_ready  = ready;
  assign apb.p_slverr = ready & req.err;
  assign apb.p_rdata  = (ready && !req.wr && !req.err) ? mem[req.idx] : 32'h0;
endmodule
